led_bar_arbiter: RTL and testbench

LED_BAR_ARBITER -- requirements
Module: led_bar_arbiter

---
 rtl/led_bar_arbiter.sv | 169 ++++++++++++++++
 tb/tb_led_bar_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/led_bar_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : led_bar_arbiter
// Brief    : Time-sliced round-robin arbiter sharing one 8-LED bar among four
//            requesters. Optional macro LED_ARB_BLANK_EN inserts a blank
//            period (until the next tick) at every ownership end.
// Revision : 1.0 - initial release
// ============================================================================
module led_bar_arbiter #(
  parameter int unsigned CLK_FREQ    = 48_000_000,
  parameter int unsigned TICK_HZ     = 30,
  parameter int unsigned SLICE_TICKS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [31:0] pat,
  output logic [3:0]  grant,
  output logic [7:0]  cats,
  output logic        tick
);

  localparam int unsigned        C_DIV_N     = CLK_FREQ / TICK_HZ;
  localparam int unsigned        C_DIV_W     = (C_DIV_N > 1) ? $clog2(C_DIV_N) : 1;
  localparam logic [C_DIV_W-1:0] C_DIV_MAX   = C_DIV_W'(C_DIV_N - 1);
  localparam logic [7:0]         C_SLICE_MAX = 8'(SLICE_TICKS - 1);

`ifdef LED_ARB_BLANK_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN   = 2'd1,
    S_BLANK = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN   = 2'd1
  } state_t;
`endif

  state_t             r_state, w_state_nxt;
  logic [1:0]         r_owner, w_owner_nxt;
  logic [1:0]         r_last_owner, w_last_nxt;
  logic [7:0]         r_slice_cnt, w_slice_nxt;
  logic [C_DIV_W-1:0] r_div;
  logic               r_tick;
  logic [3:0]         r_grant;
  logic [7:0]         r_cats, w_cats_nxt;
  logic [3:0]         w_owner_mask;
  logic               w_other;

  // First set request bit scanning base+1 .. base+4 (mod 4)
  function automatic logic [1:0] f_pick(input logic [1:0] base, input logic [3:0] r);
    logic [1:0] idx;
    logic [1:0] res;
    logic       found;
    res   = base;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = base + 2'(k);
      if (!found && r[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_div  <= (r_div == C_DIV_MAX) ? '0 : r_div + 1'b1;
      r_tick <= (r_div == C_DIV_MAX);
    end
  end

  assign w_owner_mask = 4'b0001 << r_owner;
  assign w_other      = |(req & ~w_owner_mask);

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last_owner;
    w_slice_nxt = r_slice_cnt;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_state_nxt = S_OWN;
          w_owner_nxt = f_pick(r_last_owner, req);
          w_slice_nxt = '0;
        end
      end
      S_OWN: begin
        // Release outranks expiry when both land on the same clk
        if (!req[r_owner]) begin
          w_last_nxt  = r_owner;
          w_slice_nxt = '0;
`ifdef LED_ARB_BLANK_EN
          w_state_nxt = S_BLANK;
`else
          w_state_nxt = S_IDLE;
`endif
        end else if (r_tick) begin
          if (r_slice_cnt == C_SLICE_MAX) begin
            if (w_other) begin
              w_last_nxt  = r_owner;
              w_slice_nxt = '0;
`ifdef LED_ARB_BLANK_EN
              w_state_nxt = S_BLANK;
`else
              w_owner_nxt = f_pick(r_owner, req);
`endif
            end
          end else begin
            w_slice_nxt = r_slice_cnt + 8'd1;
          end
        end
      end
`ifdef LED_ARB_BLANK_EN
      S_BLANK: begin
        if (r_tick) begin
          w_state_nxt = S_IDLE;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Bar shows the pattern of whoever held grant on the previous clk
  always_comb begin
    w_cats_nxt = '0;
    if (r_state == S_OWN) begin
      for (int i = 0; i < 4; i++) begin
        if (r_grant[i]) begin
          w_cats_nxt = pat[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_owner      <= 2'd0;
      r_last_owner <= 2'd3;
      r_slice_cnt  <= '0;
      r_grant      <= '0;
      r_cats       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_nxt;
      r_slice_cnt  <= w_slice_nxt;
      r_grant      <= (r_state == S_OWN) ? w_owner_mask : 4'b0000;
      r_cats       <= w_cats_nxt;
    end
  end

  assign grant = r_grant;
  assign cats  = r_cats;
  assign tick  = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_led_bar_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_bar_arbiter
// Brief    : Directed self-checking bench for led_bar_arbiter (10 clk/tick,
//            4-tick slices). Honours LED_ARB_BLANK_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_bar_arbiter;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req   = 4'b0000;
  logic [31:0] pat   = 32'h0;
  logic [3:0]  grant;
  logic [7:0]  cats;
  logic        tick;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  led_bar_arbiter #(
    .CLK_FREQ    (300),
    .TICK_HZ     (30),
    .SLICE_TICKS (4)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .pat   (pat),
    .grant (grant),
    .cats  (cats),
    .tick  (tick)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves rst_n released 1 time unit after an edge; the next edge is edge 1
  task automatic do_reset(input logic [3:0] r);
    rst_n = 1'b0;
    req   = r;
    step(2);
    rst_n = 1'b1;
  endtask

  logic zero_seen;
  logic multi_seen;

  initial begin
    // Reset state and first grant / tick latency
    pat   = 32'h0000_005A;
    req   = 4'b0001;
    rst_n = 1'b0;
    step(2);
    check_eq("rst_grant", grant, 4'b0000);
    check_eq("rst_cats", cats, 8'h00);
    check_eq("rst_tick", tick, 1'b0);
    rst_n = 1'b1;
    step(1);
    check_eq("first_grant_e1", grant, 4'b0000);
    step(1);
    check_eq("first_grant_e2", grant, 4'b0001);
    check_eq("first_cats_e2", cats, 8'h00);
    step(1);
    check_eq("first_cats_e3", cats, 8'h5A);
    step(6);
    check_eq("tick_e9", tick, 1'b0);
    step(1);
    check_eq("tick_e10", tick, 1'b1);
    step(1);
    check_eq("tick_e11", tick, 1'b0);

    // Two requesters held: alternating slices
    pat = 32'h4433_2211;
    do_reset(4'b0011);
    zero_seen  = 1'b0;
    multi_seen = 1'b0;
    for (int e = 1; e <= 90; e++) begin
      step(1);
      if (e >= 2 && grant == 4'b0000) zero_seen = 1'b1;
      if ($countones(grant) > 1) multi_seen = 1'b1;
`ifdef LED_ARB_BLANK_EN
      if (e == 41) check_eq("blank_e41_grant", grant, 4'b0001);
      if (e == 42) check_eq("blank_e42_grant", grant, 4'b0000);
      if (e == 42) check_eq("blank_e42_cats", cats, 8'h00);
      if (e == 52) check_eq("blank_e52_grant", grant, 4'b0000);
      if (e == 53) check_eq("blank_e53_grant", grant, 4'b0010);
`else
      if (e == 41) check_eq("alt_e41_grant", grant, 4'b0001);
      if (e == 42) check_eq("alt_e42_grant", grant, 4'b0010);
      if (e == 42) check_eq("alt_e42_cats", cats, 8'h11);
      if (e == 43) check_eq("alt_e43_cats", cats, 8'h22);
      if (e == 81) check_eq("alt_e81_grant", grant, 4'b0010);
      if (e == 82) check_eq("alt_e82_grant", grant, 4'b0001);
`endif
    end
`ifndef LED_ARB_BLANK_EN
    check_eq("alt_no_zero_gap", zero_seen, 1'b0);
`endif
    check_eq("alt_onehot", multi_seen, 1'b0);

`ifndef LED_ARB_BLANK_EN
    // Release on the expiry clk beats handover
    do_reset(4'b0101);
    for (int e = 1; e <= 43; e++) begin
      step(1);
      if (e == 40) req = 4'b0100;
      if (e == 41) check_eq("rel_e41_grant", grant, 4'b0001);
      if (e == 42) check_eq("rel_e42_grant", grant, 4'b0000);
      if (e == 42) check_eq("rel_e42_cats", cats, 8'h00);
      if (e == 43) check_eq("rel_e43_grant", grant, 4'b0100);
    end
`endif

    // Lone requester 3 keeps the bar; yields to requester 1 on next tick
    do_reset(4'b1000);
    for (int e = 1; e <= 212; e++) begin
      step(1);
      if (e == 2)   check_eq("solo_e2_grant", grant, 4'b1000);
      if (e == 200) check_eq("solo_e200_grant", grant, 4'b1000);
      if (e == 201) check_eq("solo_e201_grant", grant, 4'b1000);
      if (e == 201) req = 4'b1010;
      if (e == 211) check_eq("solo_e211_grant", grant, 4'b1000);
      if (e == 211) check_eq("solo_e211_cats", cats, 8'h44);
`ifdef LED_ARB_BLANK_EN
      if (e == 212) check_eq("solo_e212_grant", grant, 4'b0000);
`else
      if (e == 212) check_eq("solo_e212_grant", grant, 4'b0010);
`endif
    end
`ifndef LED_ARB_BLANK_EN
    step(1);
    check_eq("solo_e213_cats", cats, 8'h22);
`endif

    // Asynchronous reset mid-ownership, then requester 0 wins
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("async_grant", grant, 4'b0000);
    check_eq("async_cats", cats, 8'h00);
    req = 4'b1111;
    step(1);
    check_eq("inrst_grant", grant, 4'b0000);
    rst_n = 1'b1;
    step(2);
    check_eq("post_rst_grant", grant, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
